rs_alu: RTL and testbench
=========================

// Module: rs_alu
// PURPOSE
// Reservation station feeding the combinational ALU: buffers issued arithmetic/branch/jump ops,
// snoops both CDBs (ALU and LSB) to resolve pending operands, and each cycle dispatches one
// ready entry to the ALU as registered ALU_S/Op/Vj/Vk/Reorder/A/pc. Sits between dispatcher and ALU.
// It is the producer end of the ALU input interface and a consumer of the ALU's CDB output.
// PARAMETERS
// RS_SIZE   16  number of entries (power of two, >=2)
// IDX_W     4   log2(RS_SIZE)
// PORTS
// clk            in   1        clock, rising edge
// rst            in   1        asynchronous, active-low reset
// clear          in   1        misprediction flush, synchronous
// Issue_S        in   1        dispatcher writes one entry this cycle
// Issue_Op       in   `OpBus    operation code
// Issue_Vj/Vk    in   `DataBus  operand values (valid when matching Rj/Rk=1)
// Issue_Rj/Rk    in   1        operand ready; 0 = wait on Qj/Qk
// Issue_Qj/Qk    in   `ROBBus   producing ROB tag of a pending operand
// Issue_Reorder  in   `ROBBus   destination ROB tag
// Issue_A        in   `DataBus  immediate
// Issue_pc       in   `AddrBus  instruction pc
// RS_Full        out  1        no free entry (combinational from state)
// CDB_ALU_S/Reorder/Value  in  1/`ROBBus/`DataBus  ALU broadcast
// CDB_LSB_S/Reorder/Value  in  1/`ROBBus/`DataBus  load/store broadcast
// ALU_S          out  1        registered: ALU inputs valid this cycle
// Op,Vj,Vk,Reorder,A,pc out  registered ALU operands (widths as Issue_*)
// BEHAVIOUR
// - Reset (rst=0, async): all entries free; ALU_S=0, Op/Vj/Vk/Reorder/A/pc=`Null.
// - Per entry: Busy, Op, Vj, Vk, Rj, Rk, Qj, Qk, Reorder, A, pc. Entry ready = Busy&Rj&Rk.
// - clear=1: highest priority; next edge all Busy=0, ALU_S=0; Issue_S and CDBs ignored that cycle.
// - Issue: Issue_S=1 and RS_Full=0 -> write lowest-index free entry at edge. Issue_S with
//   RS_Full=1 is dropped, state unchanged (dispatcher must not do this; checked by assertion).
// - Issue bypass: if an incoming pending operand's tag matches an active CDB this cycle,
//   the entry is written with R=1 and the CDB value.
// - Snoop: for every Busy entry with R=0 and Q==CDB_x_Reorder while CDB_x_S=1, set V=value, R=1
//   at edge. Both CDBs matching the same tag cannot occur; if it does, ALU bus wins.
// - Dispatch: selection uses registered state only. Lowest-index ready entry is copied to the
//   ALU outputs with ALU_S=1 and its Busy cleared at the same edge; none ready -> ALU_S=0,
//   other outputs `Null. An operand arriving on a CDB this cycle makes the entry eligible
//   next cycle (issue->dispatch minimum latency 1 cycle; CDB wake-up->dispatch 1 cycle).
// - ALU_S is high for exactly one cycle per dispatched op; never re-dispatch an entry.
// - RS_Full = all Busy; a same-cycle dispatch does not relieve Full until the next cycle.
// - Issue and dispatch in the same cycle are independent (different entries by construction).
// - Reset mid-operation discards all entries and any in-flight ALU_S immediately.
// STRUCTURE
// - Shared defines header: `OpBus, `ROBBus, `DataBus, `AddrBus, `Enable/`Disable, `Null,
//   op encodings, RS_SIZE default.
// - Sub-module rs_pick (combinational, instantiated twice): lowest-index-set-bit encoder over
//   RS_SIZE bits -> {found, IDX_W index}; used for free-slot and ready-slot selection.
// TESTING
// - Reset: assert rst=0 mid-traffic -> ALU_S=0, RS_Full=0, outputs `Null immediately.
// - Ready issue: ADD Vj=5 Vk=7 Rj=Rk=1 Reorder=3 -> next cycle ALU_S=1,Op=ADD,Vj=5,Vk=7,Reorder=3.
// - Wake-up: ADDI Qj=2 Rj=0 A=4; later CDB_LSB Reorder=2 Value=10 -> following cycle ALU_S=1,Vj=10.
// - Bypass: issue SUB Qk=6 while CDB_ALU Reorder=6 Value=9 same cycle -> dispatched next cycle, Vk=9.
// - Fill 16 pending entries -> RS_Full=1; extra Issue_S dropped; one CDB wake-up -> one dispatch, Full clears.
// - clear with 5 Busy and one ready -> next cycle ALU_S=0, RS_Full=0, later CDBs cause no dispatch.

Source files
------------

// File: rtl/rs_alu_pkg.sv
// Shared widths, op encodings and the entry layout for the ALU reservation station.
package rs_alu_pkg;

  localparam int unsigned OP_W        = 6;
  localparam int unsigned ROB_W       = 4;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned RS_SIZE_DEF = 16;

  typedef logic [OP_W-1:0]   op_t;
  typedef logic [ROB_W-1:0]  rob_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;

  localparam logic  ENABLE   = 1'b1;
  localparam logic  DISABLE  = 1'b0;
  localparam data_t NULL_VAL = '0;

  // Op encodings (0 is reserved as the idle/null op)
  localparam op_t OP_ADD  = 6'd1;
  localparam op_t OP_SUB  = 6'd2;
  localparam op_t OP_ADDI = 6'd3;
  localparam op_t OP_AND  = 6'd4;
  localparam op_t OP_OR   = 6'd5;
  localparam op_t OP_XOR  = 6'd6;
  localparam op_t OP_BEQ  = 6'd16;
  localparam op_t OP_BNE  = 6'd17;
  localparam op_t OP_JAL  = 6'd24;
  localparam op_t OP_JALR = 6'd25;

  typedef struct packed {
    logic  busy;
    op_t   op;
    data_t vj;
    data_t vk;
    logic  rj;
    logic  rk;
    rob_t  qj;
    rob_t  qk;
    rob_t  reorder;
    data_t a;
    addr_t pc;
  } rs_entry_t;

  typedef struct packed {
    op_t   op;
    data_t vj;
    data_t vk;
    rob_t  reorder;
    data_t a;
    addr_t pc;
  } alu_out_t;

  // Resolve one operand against both CDBs; returns {ready, value}. ALU bus wins a tie.
  function automatic logic [DATA_W:0] cdb_resolve(
    input logic  cur_r,
    input data_t cur_v,
    input rob_t  q,
    input logic  alu_s,
    input rob_t  alu_tag,
    input data_t alu_val,
    input logic  lsb_s,
    input rob_t  lsb_tag,
    input data_t lsb_val
  );
    if (cur_r) begin
      return {1'b1, cur_v};
    end else if (alu_s && (q == alu_tag)) begin
      return {1'b1, alu_val};
    end else if (lsb_s && (q == lsb_tag)) begin
      return {1'b1, lsb_val};
    end
    return {1'b0, cur_v};
  endfunction

endpackage

// File: rtl/rs_alu_pick.sv
// Lowest-index set-bit encoder: reports whether any request is set and where the first one is.
module rs_pick #(
  parameter int unsigned N     = 16,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  // Scan from the top down so the lowest set bit is the last one written
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        found_o = 1'b1;
        idx_o   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/rs_alu.sv
// ALU reservation station: buffers issued ops, snoops both CDBs for pending operands and
// dispatches the lowest-index ready entry to the ALU each cycle through registered outputs.
module rs_alu
  import rs_alu_pkg::*;
#(
  parameter int unsigned RS_SIZE = RS_SIZE_DEF,
  parameter int unsigned IDX_W   = $clog2(RS_SIZE)
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  clear,
  input  logic  Issue_S,
  input  op_t   Issue_Op,
  input  data_t Issue_Vj,
  input  data_t Issue_Vk,
  input  logic  Issue_Rj,
  input  logic  Issue_Rk,
  input  rob_t  Issue_Qj,
  input  rob_t  Issue_Qk,
  input  rob_t  Issue_Reorder,
  input  data_t Issue_A,
  input  addr_t Issue_pc,
  output logic  RS_Full,
  input  logic  CDB_ALU_S,
  input  rob_t  CDB_ALU_Reorder,
  input  data_t CDB_ALU_Value,
  input  logic  CDB_LSB_S,
  input  rob_t  CDB_LSB_Reorder,
  input  data_t CDB_LSB_Value,
  output logic  ALU_S,
  output op_t   Op,
  output data_t Vj,
  output data_t Vk,
  output rob_t  Reorder,
  output data_t A,
  output addr_t pc
);

  rs_entry_t ent_q [RS_SIZE];
  rs_entry_t ent_d [RS_SIZE];
  logic      alu_s_q, alu_s_d;
  alu_out_t  out_q, out_d;

  logic [RS_SIZE-1:0] free_vec, ready_vec;
  logic               free_found, ready_found;
  logic [IDX_W-1:0]   free_idx, ready_idx;

  // Slot status from registered state only, so dispatch never sees same-cycle wake-ups
  always_comb begin
    free_vec  = '0;
    ready_vec = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      free_vec[i]  = ~ent_q[i].busy;
      ready_vec[i] = ent_q[i].busy & ent_q[i].rj & ent_q[i].rk;
    end
  end

  assign RS_Full = ~|free_vec;

  rs_pick #(
    .N     (RS_SIZE),
    .IDX_W (IDX_W)
  ) u_pick_free (
    .req_i   (free_vec),
    .found_o (free_found),
    .idx_o   (free_idx)
  );

  rs_pick #(
    .N     (RS_SIZE),
    .IDX_W (IDX_W)
  ) u_pick_ready (
    .req_i   (ready_vec),
    .found_o (ready_found),
    .idx_o   (ready_idx)
  );

  // Next state: flush, else snoop + dispatch + issue (issue targets a free slot, dispatch a
  // busy one, so they never collide)
  always_comb begin
    ent_d   = ent_q;
    alu_s_d = DISABLE;
    out_d   = '0;
    if (clear) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        ent_d[i].busy = 1'b0;
      end
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (ent_q[i].busy) begin
          {ent_d[i].rj, ent_d[i].vj} = cdb_resolve(ent_q[i].rj, ent_q[i].vj, ent_q[i].qj,
              CDB_ALU_S, CDB_ALU_Reorder, CDB_ALU_Value,
              CDB_LSB_S, CDB_LSB_Reorder, CDB_LSB_Value);
          {ent_d[i].rk, ent_d[i].vk} = cdb_resolve(ent_q[i].rk, ent_q[i].vk, ent_q[i].qk,
              CDB_ALU_S, CDB_ALU_Reorder, CDB_ALU_Value,
              CDB_LSB_S, CDB_LSB_Reorder, CDB_LSB_Value);
        end
      end
      if (ready_found) begin
        alu_s_d       = ENABLE;
        out_d.op      = ent_q[ready_idx].op;
        out_d.vj      = ent_q[ready_idx].vj;
        out_d.vk      = ent_q[ready_idx].vk;
        out_d.reorder = ent_q[ready_idx].reorder;
        out_d.a       = ent_q[ready_idx].a;
        out_d.pc      = ent_q[ready_idx].pc;
        ent_d[ready_idx].busy = 1'b0;
      end
      if (Issue_S && free_found) begin
        ent_d[free_idx].busy    = 1'b1;
        ent_d[free_idx].op      = Issue_Op;
        ent_d[free_idx].qj      = Issue_Qj;
        ent_d[free_idx].qk      = Issue_Qk;
        ent_d[free_idx].reorder = Issue_Reorder;
        ent_d[free_idx].a       = Issue_A;
        ent_d[free_idx].pc      = Issue_pc;
        {ent_d[free_idx].rj, ent_d[free_idx].vj} = cdb_resolve(Issue_Rj, Issue_Vj, Issue_Qj,
            CDB_ALU_S, CDB_ALU_Reorder, CDB_ALU_Value,
            CDB_LSB_S, CDB_LSB_Reorder, CDB_LSB_Value);
        {ent_d[free_idx].rk, ent_d[free_idx].vk} = cdb_resolve(Issue_Rk, Issue_Vk, Issue_Qk,
            CDB_ALU_S, CDB_ALU_Reorder, CDB_ALU_Value,
            CDB_LSB_S, CDB_LSB_Reorder, CDB_LSB_Value);
      end
    end
  end

  // Entry storage and registered ALU interface
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        ent_q[i] <= '0;
      end
      alu_s_q <= DISABLE;
      out_q   <= '0;
    end else begin
      ent_q   <= ent_d;
      alu_s_q <= alu_s_d;
      out_q   <= out_d;
    end
  end

  assign ALU_S   = alu_s_q;
  assign Op      = out_q.op;
  assign Vj      = out_q.vj;
  assign Vk      = out_q.vk;
  assign Reorder = out_q.reorder;
  assign A       = out_q.a;
  assign pc      = out_q.pc;

  // The dispatcher must hold off while full
  a_no_issue_when_full: assert property (@(posedge clk) disable iff (!rst)
    !(Issue_S && RS_Full));

endmodule

// File: tb/tb_rs_alu.sv
// Randomized and directed bench for rs_alu against an entry-table reference model.
module tb_rs_alu;
  import rs_alu_pkg::*;

  localparam int unsigned N = 16;

  logic  clk = 1'b0, rst = 1'b0, clear = 1'b0;
  logic  Issue_S = 1'b0, Issue_Rj = 1'b0, Issue_Rk = 1'b0;
  op_t   Issue_Op = '0;
  data_t Issue_Vj = '0, Issue_Vk = '0, Issue_A = '0;
  rob_t  Issue_Qj = '0, Issue_Qk = '0, Issue_Reorder = '0;
  addr_t Issue_pc = '0;
  logic  CDB_ALU_S = 1'b0, CDB_LSB_S = 1'b0;
  rob_t  CDB_ALU_Reorder = '0, CDB_LSB_Reorder = '0;
  data_t CDB_ALU_Value = '0, CDB_LSB_Value = '0;
  logic  RS_Full, ALU_S;
  op_t   Op;
  data_t Vj, Vk, A;
  rob_t  Reorder;
  addr_t pc;

  rs_alu dut (
    .clk(clk), .rst(rst), .clear(clear),
    .Issue_S(Issue_S), .Issue_Op(Issue_Op), .Issue_Vj(Issue_Vj), .Issue_Vk(Issue_Vk),
    .Issue_Rj(Issue_Rj), .Issue_Rk(Issue_Rk), .Issue_Qj(Issue_Qj), .Issue_Qk(Issue_Qk),
    .Issue_Reorder(Issue_Reorder), .Issue_A(Issue_A), .Issue_pc(Issue_pc),
    .RS_Full(RS_Full),
    .CDB_ALU_S(CDB_ALU_S), .CDB_ALU_Reorder(CDB_ALU_Reorder), .CDB_ALU_Value(CDB_ALU_Value),
    .CDB_LSB_S(CDB_LSB_S), .CDB_LSB_Reorder(CDB_LSB_Reorder), .CDB_LSB_Value(CDB_LSB_Value),
    .ALU_S(ALU_S), .Op(Op), .Vj(Vj), .Vk(Vk), .Reorder(Reorder), .A(A), .pc(pc)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: table of reservation entries plus expected ALU outputs
  logic  m_busy [N];
  logic  m_rj [N], m_rk [N];
  op_t   m_op [N];
  data_t m_vj [N], m_vk [N], m_a [N];
  rob_t  m_qj [N], m_qk [N], m_ro [N];
  addr_t m_pc [N];
  logic  e_s;
  op_t   e_op;
  data_t e_vj, e_vk, e_a;
  rob_t  e_ro;
  addr_t e_pc;

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
    e_s = 0; e_op = '0; e_vj = '0; e_vk = '0; e_a = '0; e_ro = '0; e_pc = '0;
  endtask

  function automatic logic model_full();
    for (int i = 0; i < N; i++) if (!m_busy[i]) return 1'b0;
    return 1'b1;
  endfunction

  // {hit, value} of whichever broadcast carries tag q this cycle
  function automatic logic [DATA_W:0] bcast(input rob_t q);
    if (CDB_ALU_S && CDB_ALU_Reorder == q) return {1'b1, CDB_ALU_Value};
    if (CDB_LSB_S && CDB_LSB_Reorder == q) return {1'b1, CDB_LSB_Value};
    return '0;
  endfunction

  task automatic model_step();
    int r, f;
    logic [DATA_W:0] t;
    r = -1; f = -1;
    for (int i = 0; i < N; i++) begin
      if (r < 0 && m_busy[i] && m_rj[i] && m_rk[i]) r = i;
      if (f < 0 && !m_busy[i]) f = i;
    end
    e_s = 0; e_op = '0; e_vj = '0; e_vk = '0; e_a = '0; e_ro = '0; e_pc = '0;
    if (clear) begin
      for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
      return;
    end
    for (int i = 0; i < N; i++) begin
      if (m_busy[i] && !m_rj[i]) begin
        t = bcast(m_qj[i]);
        if (t[DATA_W]) begin m_rj[i] = 1'b1; m_vj[i] = t[DATA_W-1:0]; end
      end
      if (m_busy[i] && !m_rk[i]) begin
        t = bcast(m_qk[i]);
        if (t[DATA_W]) begin m_rk[i] = 1'b1; m_vk[i] = t[DATA_W-1:0]; end
      end
    end
    if (r >= 0) begin
      e_s = 1; e_op = m_op[r]; e_vj = m_vj[r]; e_vk = m_vk[r];
      e_ro = m_ro[r]; e_a = m_a[r]; e_pc = m_pc[r];
      m_busy[r] = 1'b0;
    end
    if (Issue_S && f >= 0) begin
      m_busy[f] = 1'b1; m_op[f] = Issue_Op; m_ro[f] = Issue_Reorder;
      m_a[f] = Issue_A; m_pc[f] = Issue_pc; m_qj[f] = Issue_Qj; m_qk[f] = Issue_Qk;
      m_rj[f] = Issue_Rj; m_vj[f] = Issue_Vj; m_rk[f] = Issue_Rk; m_vk[f] = Issue_Vk;
      if (!Issue_Rj) begin
        t = bcast(Issue_Qj);
        if (t[DATA_W]) begin m_rj[f] = 1'b1; m_vj[f] = t[DATA_W-1:0]; end
      end
      if (!Issue_Rk) begin
        t = bcast(Issue_Qk);
        if (t[DATA_W]) begin m_rk[f] = 1'b1; m_vk[f] = t[DATA_W-1:0]; end
      end
    end
  endtask

  task automatic compare_all();
    check_eq("ALU_S", 64'(ALU_S), 64'(e_s));
    check_eq("Op", 64'(Op), 64'(e_op));
    check_eq("Vj", 64'(Vj), 64'(e_vj));
    check_eq("Vk", 64'(Vk), 64'(e_vk));
    check_eq("Reorder", 64'(Reorder), 64'(e_ro));
    check_eq("A", 64'(A), 64'(e_a));
    check_eq("pc", 64'(pc), 64'(e_pc));
    check_eq("RS_Full", 64'(RS_Full), 64'(model_full()));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic set_idle();
    Issue_S = 0; CDB_ALU_S = 0; CDB_LSB_S = 0; clear = 0;
  endtask

  task automatic set_issue(input op_t op, input data_t vj, input data_t vk, input logic rj,
                           input logic rk, input rob_t qj, input rob_t qk, input rob_t ro,
                           input data_t a, input addr_t p);
    Issue_S = 1; Issue_Op = op; Issue_Vj = vj; Issue_Vk = vk; Issue_Rj = rj; Issue_Rk = rk;
    Issue_Qj = qj; Issue_Qk = qk; Issue_Reorder = ro; Issue_A = a; Issue_pc = p;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ALU_S"}, 64'(ALU_S), 64'd0);
    check_eq({tag, "_RS_Full"}, 64'(RS_Full), 64'd0);
    check_eq({tag, "_outs"}, {26'd0, Op, Reorder, Vj}, 64'd0);
    check_eq({tag, "_outs2"}, {Vk, A | pc}, 64'd0);
  endtask

  initial begin
    model_reset();
    #3;
    check_reset_outputs("reset_init");
    @(negedge clk);
    rst = 1;

    // Ready issue: dispatched one cycle after the entry is written
    set_issue(OP_ADD, 32'd5, 32'd7, 1, 1, 4'd0, 4'd0, 4'd3, 32'd0, 32'h100);
    tick();
    set_idle();
    tick();
    check_eq("rdy_S", 64'(ALU_S), 64'd1);
    check_eq("rdy_Op", 64'(Op), 64'(OP_ADD));
    check_eq("rdy_VjVk", {Vj, Vk}, {32'd5, 32'd7});
    check_eq("rdy_Reorder", 64'(Reorder), 64'd3);

    // Wake-up via LSB bus
    set_issue(OP_ADDI, 32'd0, 32'd0, 0, 1, 4'd2, 4'd0, 4'd4, 32'd4, 32'h104);
    tick();
    set_idle();
    CDB_LSB_S = 1; CDB_LSB_Reorder = 4'd2; CDB_LSB_Value = 32'd10;
    tick();
    set_idle();
    check_eq("wake_early", 64'(ALU_S), 64'd0);
    tick();
    check_eq("wake_S", 64'(ALU_S), 64'd1);
    check_eq("wake_Vj", 64'(Vj), 64'd10);
    check_eq("wake_A", 64'(A), 64'd4);

    // Issue bypass from the ALU bus
    set_issue(OP_SUB, 32'd20, 32'd0, 1, 0, 4'd0, 4'd6, 4'd5, 32'd0, 32'h108);
    CDB_ALU_S = 1; CDB_ALU_Reorder = 4'd6; CDB_ALU_Value = 32'd9;
    tick();
    set_idle();
    tick();
    check_eq("byp_S", 64'(ALU_S), 64'd1);
    check_eq("byp_Vk", 64'(Vk), 64'd9);

    // Fill all entries with pending ops
    for (int i = 0; i < N; i++) begin
      set_issue(OP_ADD, 32'd0, 32'd1, 0, 1, rob_t'(i), 4'd0, rob_t'(i), 32'd0, 32'(i));
      tick();
    end
    set_idle();
    check_eq("fill_full", 64'(RS_Full), 64'd1);
    CDB_ALU_S = 1; CDB_ALU_Reorder = 4'd5; CDB_ALU_Value = 32'd55;
    tick();
    set_idle();
    check_eq("fill_still_full", 64'(RS_Full), 64'd1);
    tick();
    check_eq("fill_disp_S", 64'(ALU_S), 64'd1);
    check_eq("fill_disp_Vj", 64'(Vj), 64'd55);
    check_eq("fill_disp_Reorder", 64'(Reorder), 64'd5);
    check_eq("fill_full_clears", 64'(RS_Full), 64'd0);

    // Flush, then 4 pending + 1 ready, then flush again while one is ready
    clear = 1;
    tick();
    set_idle();
    for (int i = 1; i <= 4; i++) begin
      set_issue(OP_OR, 32'd0, 32'd0, 0, 1, rob_t'(i), 4'd0, rob_t'(i + 8), 32'd0, 32'h200);
      tick();
    end
    set_issue(OP_XOR, 32'd1, 32'd2, 1, 1, 4'd0, 4'd0, 4'd15, 32'd0, 32'h210);
    tick();
    set_idle();
    clear = 1;
    tick();
    set_idle();
    check_eq("clr_S", 64'(ALU_S), 64'd0);
    check_eq("clr_Full", 64'(RS_Full), 64'd0);
    for (int i = 1; i <= 5; i++) begin
      set_idle();
      if (i <= 4) begin
        CDB_ALU_S = 1; CDB_ALU_Reorder = rob_t'(i); CDB_ALU_Value = 32'(i);
      end
      tick();
      check_eq("clr_no_disp", 64'(ALU_S), 64'd0);
    end

    // Randomized traffic with occasional flush and one asynchronous reset
    for (int it = 0; it < 1500; it++) begin
      set_idle();
      if (!model_full() && $urandom_range(0, 2) != 0) begin
        set_issue(op_t'($urandom), data_t'($urandom), data_t'($urandom),
                  logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
                  rob_t'($urandom), rob_t'($urandom), rob_t'($urandom),
                  data_t'($urandom), addr_t'($urandom));
      end
      CDB_ALU_S = logic'($urandom_range(0, 1));
      CDB_ALU_Reorder = rob_t'($urandom);
      CDB_ALU_Value = data_t'($urandom);
      CDB_LSB_S = logic'($urandom_range(0, 1));
      CDB_LSB_Reorder = rob_t'($urandom);
      CDB_LSB_Value = data_t'($urandom);
      clear = ($urandom_range(0, 99) == 0);
      tick();
      if (it == 750) begin
        #1;
        rst = 0;
        #1;
        check_reset_outputs("reset_mid");
        model_reset();
        @(negedge clk);
        rst = 1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
